spi2dac_ctrl: RTL and testbench
===============================

// Module: spi2dac_ctrl
// PURPOSE
//  Downstream stage of the echo processor. Takes each 10-bit offset-binary sample
//  (processor data_out, strobed by load) and serialises it to the MCP4911 SPI DAC:
//  one 16-bit frame, then an LDAC pulse. Sits between the processor and the DAC pins.
//  Reports busy/done and flags samples lost to overrun.
// PARAMETERS
//  CLK_DIV   4        sysclk cycles per SPI half-period (tick); legal range 1..255
//  CFG_BITS  4'b0111  frame[15:12]: A/B=0, BUF=1, GA_n=1 (1x gain), SHDN_n=1
// PORTS
//  sysclk     in   1   system clock; all logic on posedge
//  reset      in   1   asynchronous, active-high reset
//  data_in    in   10  sample to convert (offset binary, 512 = mid-scale)
//  load       in   1   1-cycle strobe: data_in valid this cycle
//  dac_cs     out  1   SPI chip select, active low
//  dac_sck    out  1   SPI clock; idles low
//  dac_sdi    out  1   SPI data, MSB first
//  dac_ld     out  1   LDAC, active low; 1-tick pulse after each frame
//  busy       out  1   high while a frame (or pending sample) is in progress
//  done       out  1   1-cycle pulse when LDAC completes
//  overrun    out  1   1-cycle pulse when a sample is dropped
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, dac_cs=1, dac_sck=0, dac_sdi=0, dac_ld=1,
//   busy=0, done=0, overrun=0, tick counter=0, pending cleared. A frame in flight is
//   abandoned; cs returns high immediately; no LDAC is issued.
//  tick: 1-cycle enable every CLK_DIV sysclk cycles. Divider free-runs only outside IDLE
//   and restarts at 0 on leaving IDLE.
//  Frame word = {CFG_BITS, data_in, 2'b00}, latched on the load cycle in IDLE.
//  FSM (transitions on tick unless noted):
//   IDLE    : load=1 -> CS_SU (same edge: latch word, busy=1)
//   CS_SU   : cs=0, sck=0, sdi=word[15]; 1 tick -> SHIFT
//   SHIFT   : 32 ticks. Even ticks: sck=1 (DAC samples on rising edge).
//             Odd ticks: sck=0, sdi <- next bit. After 16th falling edge -> CS_HD
//   CS_HD   : sck=0, sdi=0; 1 tick, then cs=1 -> LDAC
//   LDAC    : dac_ld=0 for 1 tick, then dac_ld=1, done=1 for 1 cycle -> IDLE (or CS_SU
//             if a pending sample exists; busy stays 1)
//  Latency: load edge to done pulse = 35 ticks + 1 cycle (CLK_DIV=1: 36 cycles).
//  Max sample rate without loss = sysclk / (35*CLK_DIV + 1).
//  load while not IDLE: see CONFIGURATION. load and done in the same cycle: treated as
//   load while busy (the sample is not lost when pending is enabled).
//  Outputs are registered; no combinational path from inputs to pins.
// CONFIGURATION
//  SPI2DAC_PEND_EN defined: one-deep pending register. load while busy stores data_in
//   as pending. A second load while pending is full overwrites it and pulses overrun.
//   On LDAC completion, pending goes to CS_SU without passing through IDLE.
//  Not defined: load while busy is ignored and pulses overrun for 1 cycle; no pending
//   register is synthesised.
// TESTING
//  1 CLK_DIV=1, load data_in=10'h200 -> 16 bits on sdi sampled at sck rise = 16'h7800;
//    cs low for the whole frame; dac_ld low 1 cycle; done exactly 36 cycles after load.
//  2 data_in=10'h3FF, then 10'h000 in separate frames -> 16'h7FFC, then 16'h7000;
//    CLK_DIV=4: sck high/low 4 cycles each.
//  3 Assert reset at the 7th rising edge of sck mid-frame -> same cycle: cs=1, sck=0,
//    ld=1, busy=0; no done. Next load sends a clean full frame.
//  4 PEND_EN: loads 10'h100, then 10'h101 at cycle 5 -> two back-to-back frames
//    16'h7400, then 16'h7404; 2 done pulses; overrun never asserted.
//  5 PEND_EN: 3 loads within one frame -> the 1st and 3rd samples are sent, 1 overrun
//    pulse. Without PEND_EN: only the 1st is sent, 2 overrun pulses.
//  6 Idle with no load for 1000 cycles -> cs=1, ld=1, sck=0, busy=0 throughout.

Source files
------------

// File: rtl/spi2dac_ctrl.sv
// rtl/spi2dac_ctrl.sv - MCP4911 SPI DAC frame serialiser with LDAC strobe
// Optional macro SPI2DAC_PEND_EN adds a one-deep pending sample register;
// without it, a load that arrives while a frame is in progress is dropped.
module spi2dac_ctrl #(
  parameter int unsigned CLK_DIV  = 4,
  parameter logic [3:0]  CFG_BITS = 4'b0111
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic [9:0] data_in,
  input  logic       load,
  output logic       dac_cs,
  output logic       dac_sck,
  output logic       dac_sdi,
  output logic       dac_ld,
  output logic       busy,
  output logic       done,
  output logic       overrun
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CS_SU = 3'd1,
    SHIFT = 3'd2,
    CS_HD = 3'd3,
    LDAC  = 3'd4
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t      state;
  logic [7:0]  div_cnt;
  logic        tick;
  logic [4:0]  bit_cnt;
  // Bits 14..0 of the frame word; bit 15 goes straight to dac_sdi at frame start.
  logic [14:0] shreg;

  logic        accept;
  logic        start_idle;
  logic        lost_load;
  logic [9:0]  start_data;

`ifdef SPI2DAC_PEND_EN
  logic [9:0]  pend_data;
  logic        pend_valid;
  logic        pend_take;

  // A pending sample is consumed when the FSM starts a frame from it this edge.
  assign pend_take  = pend_valid && ((state == IDLE) || ((state == LDAC) && tick));
  assign start_data = pend_valid ? pend_data : data_in;
  assign accept     = (state == IDLE) && !pend_valid && load && !done;
  assign start_idle = (state == IDLE) && (pend_valid || (load && !done));
`else
  assign start_data = data_in;
  assign accept     = (state == IDLE) && load && !done;
  assign start_idle = accept;
`endif

  // Any load not taken directly from IDLE counts as arriving while busy,
  // including one that coincides with the done pulse.
  assign lost_load = load && !accept;

  // Tick divider: held at zero in IDLE, free-running while a frame is active.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      div_cnt <= 8'd0;
      tick    <= 1'b0;
    end else if (state == IDLE) begin
      div_cnt <= 8'd0;
      tick    <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= 8'd0;
      tick    <= 1'b1;
    end else begin
      div_cnt <= div_cnt + 8'd1;
      tick    <= 1'b0;
    end
  end

  // Frame sequencer: chip select setup, 16-bit shift, hold, LDAC pulse.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      dac_cs     <= 1'b1;
      dac_sck    <= 1'b0;
      dac_sdi    <= 1'b0;
      dac_ld     <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      overrun    <= 1'b0;
      bit_cnt    <= 5'd0;
      shreg      <= 15'd0;
`ifdef SPI2DAC_PEND_EN
      pend_data  <= 10'd0;
      pend_valid <= 1'b0;
`endif
    end else begin
      done    <= 1'b0;
      overrun <= 1'b0;
      case (state)
        IDLE: begin
          if (start_idle) begin
            state   <= CS_SU;
            busy    <= 1'b1;
            dac_cs  <= 1'b0;
            dac_sck <= 1'b0;
            dac_sdi <= CFG_BITS[3];
            shreg   <= {CFG_BITS[2:0], start_data, 2'b00};
`ifdef SPI2DAC_PEND_EN
            pend_valid <= 1'b0;
`endif
          end
        end
        CS_SU: begin
          if (tick) begin
            state   <= SHIFT;
            bit_cnt <= 5'd0;
          end
        end
        SHIFT: begin
          if (tick) begin
            bit_cnt <= bit_cnt + 5'd1;
            if (!bit_cnt[0]) begin
              dac_sck <= 1'b1;
            end else begin
              dac_sck <= 1'b0;
              if (bit_cnt == 5'd31) begin
                dac_sdi <= 1'b0;
                state   <= CS_HD;
              end else begin
                dac_sdi <= shreg[14];
                shreg   <= {shreg[13:0], 1'b0};
              end
            end
          end
        end
        CS_HD: begin
          if (tick) begin
            dac_cs <= 1'b1;
            dac_ld <= 1'b0;
            state  <= LDAC;
          end
        end
        LDAC: begin
          if (tick) begin
            dac_ld <= 1'b1;
            done   <= 1'b1;
`ifdef SPI2DAC_PEND_EN
            if (pend_valid) begin
              state      <= CS_SU;
              dac_cs     <= 1'b0;
              dac_sdi    <= CFG_BITS[3];
              shreg      <= {CFG_BITS[2:0], pend_data, 2'b00};
              pend_valid <= 1'b0;
            end else
`endif
            begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase

`ifdef SPI2DAC_PEND_EN
      // Park a late sample; overwriting an unconsumed one loses it.
      if (lost_load) begin
        pend_data  <= data_in;
        pend_valid <= 1'b1;
        busy       <= 1'b1;
        if (pend_valid && !pend_take) overrun <= 1'b1;
      end
`else
      if (lost_load) overrun <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_spi2dac_ctrl.sv
// tb/tb_spi2dac_ctrl.sv - directed bench for spi2dac_ctrl (CLK_DIV=1 and CLK_DIV=4 instances)
module tb_spi2dac_ctrl;

  logic       sysclk = 1'b0;
  logic       rst    = 1'b1;
  logic [9:0] din0   = '0;
  logic [9:0] din1   = '0;
  logic       load0  = 1'b0;
  logic       load1  = 1'b0;
  logic [1:0] cs, sck, sdi, ld, busy, done, ovr;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 sysclk = ~sysclk;

  spi2dac_ctrl #(.CLK_DIV(1), .CFG_BITS(4'b0111)) dut_div1 (
    .sysclk(sysclk), .reset(rst), .data_in(din0), .load(load0),
    .dac_cs(cs[0]), .dac_sck(sck[0]), .dac_sdi(sdi[0]), .dac_ld(ld[0]),
    .busy(busy[0]), .done(done[0]), .overrun(ovr[0])
  );

  spi2dac_ctrl #(.CLK_DIV(4), .CFG_BITS(4'b0111)) dut_div4 (
    .sysclk(sysclk), .reset(rst), .data_in(din1), .load(load1),
    .dac_cs(cs[1]), .dac_sck(sck[1]), .dac_sdi(sdi[1]), .dac_ld(ld[1]),
    .busy(busy[1]), .done(done[1]), .overrun(ovr[1])
  );

  // Pin monitor: words captured at sck rise, LDAC width, pulse counts, sck run lengths.
  logic [1:0]  psck      = '0;
  logic [1:0]  seen_fall = '0;
  logic [15:0] acc [2];
  logic [15:0] wh  [2][16];
  int nb[2], nw[2], ldlow[2], ndone[2], novr[2], csbad[2], run[2], runbad[2], nhi[2];

  function automatic int div_of(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  always @(negedge sysclk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        nb[d] = 0;
        run[d] = 0;
        seen_fall[d] = 1'b0;
      end else begin
        if (!ld[d]) begin
          ldlow[d]++;
          if (!cs[d]) csbad[d]++;
        end
        if (done[d]) ndone[d]++;
        if (ovr[d]) novr[d]++;
        if (sck[d] && cs[d]) csbad[d]++;
        if (sck[d] != psck[d]) begin
          if (psck[d]) begin
            nhi[d]++;
            if (run[d] != div_of(d)) runbad[d]++;
            seen_fall[d] = 1'b1;
          end else if (seen_fall[d] && run[d] != div_of(d)) begin
            runbad[d]++;
          end
          run[d] = 1;
        end else begin
          run[d]++;
        end
        if (cs[d]) seen_fall[d] = 1'b0;
        if (sck[d] && !psck[d]) begin
          acc[d] = {acc[d][14:0], sdi[d]};
          nb[d]++;
          if (nb[d] == 16) begin
            wh[d][nw[d] % 16] = acc[d];
            nw[d]++;
            nb[d] = 0;
          end
        end
      end
      psck[d] = sck[d];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic pulse_load(input int d, input logic [9:0] v);
    @(negedge sysclk);
    if (d == 0) begin din0 = v; load0 = 1'b1; end
    else        begin din1 = v; load1 = 1'b1; end
    @(negedge sysclk);
    load0 = 1'b0;
    load1 = 1'b0;
  endtask

  task automatic wait_done(input int d, input int budget, output int cyc);
    cyc = 0;
    while (!done[d] && cyc < budget) begin
      @(negedge sysclk);
      cyc++;
    end
  endtask

  task automatic wait_idle(input string tag, input int d, input int budget);
    int n;
    n = 0;
    while (busy[d] && n < budget) begin
      @(negedge sysclk);
      n++;
    end
    check(tag, (n >= budget) ? 1 : 0, 0);
    repeat (3) @(negedge sysclk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc, w0, o0, d0, l0, b0, h0, bad, r, n;
    logic p;

    // Reset state of both instances
    repeat (3) @(negedge sysclk);
    check("rst_pins_div1", {cs[0], sck[0], sdi[0], ld[0], busy[0], done[0], ovr[0]}, 7'b1001000);
    check("rst_pins_div4", {cs[1], sck[1], sdi[1], ld[1], busy[1], done[1], ovr[1]}, 7'b1001000);
    rst = 1'b0;

    // 1: CLK_DIV=1 mid-scale frame
    w0 = nw[0]; l0 = ldlow[0]; b0 = csbad[0];
    pulse_load(0, 10'h200);
    wait_done(0, 400, cyc);
    check("t1_latency", cyc, 36);
    repeat (4) @(negedge sysclk);
    check("t1_nwords", nw[0] - w0, 1);
    check("t1_word", wh[0][w0 % 16], 16'h7800);
    check("t1_ld_low", ldlow[0] - l0, 1);
    check("t1_cs_frame", csbad[0] - b0, 0);
    check("t1_busy_end", busy[0], 0);

    // 2: CLK_DIV=4 full-scale then zero
    w0 = nw[1]; h0 = nhi[1]; bad = runbad[1]; l0 = ldlow[1]; b0 = csbad[1];
    pulse_load(1, 10'h3FF);
    check("t2_busy_cs", {busy[1], cs[1]}, 2'b10);
    wait_done(1, 1000, cyc);
    check("t2_latency", cyc, 141);
    wait_idle("t2_idle_a", 1, 500);
    pulse_load(1, 10'h000);
    wait_idle("t2_idle_b", 1, 1000);
    check("t2_nwords", nw[1] - w0, 2);
    check("t2_word_3ff", wh[1][w0 % 16], 16'h7FFC);
    check("t2_word_000", wh[1][(w0 + 1) % 16], 16'h7000);
    check("t2_sck_highs", nhi[1] - h0, 32);
    check("t2_sck_runs", runbad[1] - bad, 0);
    check("t2_ld_low", ldlow[1] - l0, 8);
    check("t2_cs_frame", csbad[1] - b0, 0);

    // 3: reset on the 7th sck rise abandons the frame
    d0 = ndone[0];
    pulse_load(0, 10'h155);
    r = 0; p = 1'b0; n = 0;
    while (r < 7 && n < 200) begin
      @(negedge sysclk);
      n++;
      if (sck[0] && !p) r++;
      p = sck[0];
    end
    check("t3_mid_frame", {cs[0], sck[0]}, 2'b01);
    rst = 1'b1;
    #1;
    check("t3_reset_pins", {cs[0], sck[0], ld[0], busy[0]}, 4'b1010);
    repeat (2) @(negedge sysclk);
    rst = 1'b0;
    repeat (50) @(negedge sysclk);
    check("t3_no_done", ndone[0] - d0, 0);
    w0 = nw[0];
    pulse_load(0, 10'h155);
    wait_done(0, 400, cyc);
    check("t3_latency", cyc, 36);
    repeat (4) @(negedge sysclk);
    check("t3_nwords", nw[0] - w0, 1);
    check("t3_word", wh[0][w0 % 16], 16'h7554);

    // 4: second load five cycles into a frame
    w0 = nw[0]; o0 = novr[0]; d0 = ndone[0];
    pulse_load(0, 10'h100);
    repeat (3) @(negedge sysclk);
    pulse_load(0, 10'h101);
    wait_idle("t4_idle", 0, 400);
    check("t4_word_a", wh[0][w0 % 16], 16'h7400);
`ifdef SPI2DAC_PEND_EN
    check("t4_nwords", nw[0] - w0, 2);
    check("t4_word_b", wh[0][(w0 + 1) % 16], 16'h7404);
    check("t4_ndone", ndone[0] - d0, 2);
    check("t4_novr", novr[0] - o0, 0);
`else
    check("t4_nwords", nw[0] - w0, 1);
    check("t4_ndone", ndone[0] - d0, 1);
    check("t4_novr", novr[0] - o0, 1);
`endif

    // 5: three loads within one frame
    w0 = nw[0]; o0 = novr[0]; d0 = ndone[0];
    pulse_load(0, 10'h0AA);
    repeat (3) @(negedge sysclk);
    pulse_load(0, 10'h0BB);
    repeat (3) @(negedge sysclk);
    pulse_load(0, 10'h0CC);
    wait_idle("t5_idle", 0, 400);
    check("t5_word_a", wh[0][w0 % 16], 16'h72A8);
`ifdef SPI2DAC_PEND_EN
    check("t5_nwords", nw[0] - w0, 2);
    check("t5_word_b", wh[0][(w0 + 1) % 16], 16'h7330);
    check("t5_ndone", ndone[0] - d0, 2);
    check("t5_novr", novr[0] - o0, 1);
`else
    check("t5_nwords", nw[0] - w0, 1);
    check("t5_ndone", ndone[0] - d0, 1);
    check("t5_novr", novr[0] - o0, 2);
`endif

    // 6: long idle keeps the pins quiet
    bad = 0;
    repeat (1000) begin
      @(negedge sysclk);
      if (cs != 2'b11 || ld != 2'b11 || sck != 2'b00 || busy != 2'b00) bad++;
    end
    check("t6_idle_pins", bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
